pe_collect: RTL and testbench
=============================

PE_COLLECT -- requirements
Module: pe_collect

Interface
REQ-001 The block SHALL have parameter N_OUT, default 10, meaning the number of PE results per inference (MNIST classes).
REQ-002 The block SHALL have parameter DW, default 32, meaning the width of the two's-complement pe_out word.
REQ-003 The block SHALL have parameter IW, default 4, meaning the index width (ceil log2 N_OUT).
REQ-004 clock  input  1  sole clock, all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that arms a new collection.
REQ-007 pe_out  input  DW  PE accumulator result, two's complement.
REQ-008 done_flag  input  1  PE completion level; a 0->1 transition marks pe_out valid that cycle.
REQ-009 rd_addr  input  IW  read index into the stored results.
REQ-010 rd_data  output  DW  ReLU'd result at rd_addr, combinational from storage; 0 if rd_addr >= N_OUT.
REQ-011 busy  output  1  high in COLLECT.
REQ-012 result_valid  output  1  high in DONE.
REQ-013 class_idx  output  IW  index of the maximum ReLU'd result.
REQ-014 max_val  output  DW  the maximum ReLU'd value.

Function
REQ-015 The block SHALL implement states IDLE, COLLECT and DONE.
REQ-016 IDLE->COLLECT SHALL occur on start; this clears cnt, max_val, class_idx and all stored entries to 0.
REQ-017 Capture SHALL fire on the cycle where done_flag=1 and the registered done_flag is 0 (rising edge), in COLLECT only.
REQ-018 Captured value SHALL be relu = (pe_out[DW-1] ? 0 : pe_out), stored at entry cnt; cnt increments by 1.
REQ-019 Argmax SHALL update when relu > max_val (strict, unsigned compare of ReLU'd values) or on the first capture (cnt==0); ties keep the lower index.
REQ-020 COLLECT->DONE SHALL occur on the clock edge of the N_OUT-th capture; result_valid, class_idx and max_val are valid the following cycle (latency 1 from the final capture edge).
REQ-021 DONE SHALL hold outputs until start (-> COLLECT, re-armed as REQ-016).
REQ-022 Rising edges of done_flag in IDLE or DONE SHALL be ignored, with no storage or count change.
REQ-023 start during COLLECT SHALL restart the collection; a capture edge in the same cycle SHALL be discarded (start wins).
REQ-024 done_flag held high for multiple cycles SHALL produce exactly one capture.
REQ-025 All results negative SHALL give max_val=0 and class_idx=0.
REQ-026 cnt SHALL never exceed N_OUT; no wrap-around occurs.

Reset
REQ-027 reset SHALL take priority over start and capture.
REQ-028 On reset: state=IDLE, busy=0, result_valid=0, class_idx=0, max_val=0, cnt=0, stored entries=0, registered done_flag=0.
REQ-029 reset mid-COLLECT SHALL abandon partial results; a done_flag level still high after reset SHALL not capture until it falls and rises again.

Structure
REQ-030 The shared package SHALL hold the state encoding (IDLE=0, COLLECT=1, DONE=2), the default N_OUT/DW/IW and the ReLU function.
REQ-031 The edge detect SHALL be a sub-module rise_detect (1-bit registered, output = in & ~in_q).
REQ-032 Storage SHALL be a flop array of N_OUT x DW; no RAM macro.

Verification
REQ-033 Normal run: start, then 10 done_flag pulses with pe_out = 5,-3,40,7,40,0,2,-100,39,1 -> result_valid 1 cycle after the 10th capture; class_idx=2; max_val=40; rd_addr=1 reads 0; rd_addr=7 reads 0.
REQ-034 All-negative run: 10 captures of 32'h80000000..-1 -> class_idx=0, max_val=0.
REQ-035 Held done_flag: done_flag high 5 cycles with pe_out=9 -> exactly one capture (cnt=1), busy stays 1.
REQ-036 Simultaneous events: start and a rising done_flag in the same COLLECT cycle -> cnt=0, entry 0 unchanged (0).
REQ-037 Reset mid-op: reset after 4 captures with done_flag held high -> all outputs 0, IDLE; a following start then 10 fresh edges completes normally.
REQ-038 Ignored edges: done_flag pulses in IDLE and DONE -> no change to rd_data, class_idx or max_val.

Source files
------------

// File: rtl/pe_collect_pkg.sv
// Shared definitions for the PE result collector: FSM encoding, default
// geometry and the ReLU helper used on every captured accumulator word.
package pe_collect_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int N_OUT_DEF = 10;
  localparam int DW_DEF    = 32;
  localparam int IW_DEF    = 4;

  // Widest word the ReLU helper accepts; callers zero-extend into it.
  localparam int MAX_DW = 64;

  // Clamp a w-bit two's-complement value (held in the low bits of x) at zero.
  function automatic logic [MAX_DW-1:0] relu(input logic [MAX_DW-1:0] x,
                                             input int unsigned      w);
    if (((x >> (w - 1)) & MAX_DW'(1)) != '0) begin
      return '0;
    end
    return x;
  endfunction

endpackage

// File: rtl/pe_collect_if.sv
// Control/data bundle between a PE array controller and pe_collect.
interface pe_collect_if #(
  parameter int DW = pe_collect_pkg::DW_DEF,
  parameter int IW = pe_collect_pkg::IW_DEF
);

  logic          start;
  logic [DW-1:0] pe_out;
  logic          done_flag;
  logic [IW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          result_valid;
  logic [IW-1:0] class_idx;
  logic [DW-1:0] max_val;

  modport master (
    output start, pe_out, done_flag, rd_addr,
    input  rd_data, busy, result_valid, class_idx, max_val
  );

  modport slave (
    input  start, pe_out, done_flag, rd_addr,
    output rd_data, busy, result_valid, class_idx, max_val
  );

endinterface

// File: rtl/pe_collect_rise_detect.sv
// Registered 0->1 detector for the PE completion level.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in_i,
  output logic rise_o
);

  logic in_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_i;
    end
  end

  assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/pe_collect.sv
// Collects N_OUT PE results (ReLU applied), stores them in a flop array and
// tracks a running argmax; results stay readable until the next start.
module pe_collect
  import pe_collect_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int DW    = DW_DEF,
  parameter int IW    = IW_DEF
) (
  input logic         clock,
  input logic         reset,
  pe_collect_if.slave bus
);

  localparam int CW = IW + 1;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] max_q;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] mem_w [N_OUT];
  logic [DW-1:0] rd_mux;
  logic [DW-1:0] relu_val;
  logic          rise;
  logic          capture;
  logic          last_capture;
  logic          new_max;
  logic          busy_o;
  logic          valid_o;

  rise_detect u_rise (
    .clock  (clock),
    .reset  (reset),
    .in_i   (bus.done_flag),
    .rise_o (rise)
  );

  assign relu_val = DW'(relu(MAX_DW'(bus.pe_out), DW));

  // start re-arms and takes precedence over a coincident capture edge.
  assign capture      = rise & (state_q == COLLECT) & ~bus.start;
  assign last_capture = capture & (cnt_q == CW'(N_OUT - 1));
  assign new_max      = (cnt_q == '0) | (relu_val > max_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.start) begin
          state_d = COLLECT;
        end else if (last_capture) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == COLLECT);
    valid_o = (state_q == DONE);
  end

  // Running argmax; the first capture seeds it so an all-zero set reports index 0.
  always_ff @(posedge clock) begin
    if (reset || bus.start) begin
      cnt_q <= '0;
      max_q <= '0;
      idx_q <= '0;
    end else if (capture) begin
      cnt_q <= cnt_q + CW'(1);
      if (new_max) begin
        max_q <= relu_val;
        idx_q <= cnt_q[IW-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_entry
      logic [DW-1:0] entry_q;

      always_ff @(posedge clock) begin
        if (reset || bus.start) begin
          entry_q <= '0;
        end else if (capture && (cnt_q == CW'(gi))) begin
          entry_q <= relu_val;
        end
      end

      assign mem_w[gi] = entry_q;
    end
  endgenerate

  // Addresses with no matching entry fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (bus.rd_addr == IW'(i)) begin
        rd_mux = mem_w[i];
      end
    end
  end

  assign bus.rd_data      = rd_mux;
  assign bus.busy         = busy_o;
  assign bus.result_valid = valid_o;
  assign bus.class_idx    = idx_q;
  assign bus.max_val      = max_q;

endmodule

// File: tb/tb_pe_collect.sv
// Directed + randomized bench for pe_collect against a queue-based model.
module tb_pe_collect;

  localparam int N  = 10;
  localparam int DW = 32;
  localparam int IW = 4;

  localparam int M_IDLE = 0;
  localparam int M_COLL = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic rst;

  always #50 clk = ~clk;

  pe_collect_if #(.DW(DW), .IW(IW)) bus ();

  pe_collect #(.N_OUT(N), .DW(DW), .IW(IW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: collection mode, raw captured values in order, last sampled done_flag.
  int m_mode;
  int vals[$];
  bit m_prev;

  function automatic int relu_i(int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic logic [31:0] exp_rd(int a);
    if (a < vals.size()) return relu_i(vals[a]);
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_max();
    int m = 0;
    foreach (vals[k]) if (relu_i(vals[k]) > m) m = relu_i(vals[k]);
    return m;
  endfunction

  function automatic logic [31:0] exp_idx();
    int m = int'(exp_max());
    foreach (vals[k]) if (relu_i(vals[k]) == m) return k;
    return 32'd0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_mode = M_IDLE;
      vals.delete();
      m_prev = 1'b0;
    end else begin
      bit rise;
      rise = bus.done_flag && !m_prev;
      if (bus.start) begin
        m_mode = M_COLL;
        vals.delete();
      end else if (rise && m_mode == M_COLL) begin
        vals.push_back(int'(bus.pe_out));
        if (vals.size() == N) m_mode = M_DONE;
      end
      m_prev = bus.done_flag;
    end
  endtask

  task automatic check_outputs(string tag, bit sweep);
    int a;
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_mode == M_COLL));
    chk({tag, ".result_valid"}, 32'(bus.result_valid), 32'(m_mode == M_DONE));
    chk({tag, ".max_val"}, bus.max_val, exp_max());
    chk({tag, ".class_idx"}, 32'(bus.class_idx), exp_idx());
    if (sweep) begin
      for (int k = 0; k < 16; k++) begin
        bus.rd_addr = IW'(k);
        #1;
        chk($sformatf("%s.rd_data[%0d]", tag, k), bus.rd_data, exp_rd(k));
      end
    end else begin
      a = $urandom_range(0, 15);
      bus.rd_addr = IW'(a);
      #1;
      chk($sformatf("%s.rd_data[%0d]", tag, a), bus.rd_data, exp_rd(a));
    end
    $display("[TB] %s: captured=%0d busy=%0d valid=%0d max=%0d idx=%0d",
             tag, vals.size(), bus.busy, bus.result_valid, bus.max_val, bus.class_idx);
  endtask

  task automatic cycle(string tag, bit sweep = 1'b0);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag, sweep);
    @(negedge clk);
  endtask

  task automatic pulse(string tag, logic [31:0] v);
    bus.pe_out    = v;
    bus.done_flag = 1'b1;
    cycle(tag);
    bus.done_flag = 1'b0;
    bus.pe_out    = $urandom;
    cycle({tag, ".lo"});
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cycle("start");
    bus.start = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'(int'($urandom_range(0, 20)) - 10);
      2:       return 32'($urandom_range(0, 5));
      default: return 32'(-int'($urandom_range(1, 1000)));
    endcase
  endfunction

  int req033[10] = '{5, -3, 40, 7, 40, 0, 2, -100, 39, 1};

  initial begin
    int guard;
    int r;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.pe_out    = '0;
    bus.done_flag = 1'b0;
    bus.rd_addr   = '0;
    m_mode        = M_IDLE;
    m_prev        = 1'b0;
    @(negedge clk);
    cycle("reset", 1'b1);
    cycle("reset2", 1'b1);
    rst = 1'b0;
    cycle("idle");

    // Edge in IDLE must be ignored
    pulse("idle_edge", 32'd123);
    cycle("idle_chk", 1'b1);

    // Normal run
    do_start();
    for (int i = 0; i < N; i++) begin
      pulse($sformatf("req033.cap%0d", i), 32'(req033[i]));
      if (i == N - 2) chk("req033.not_yet_valid", 32'(bus.result_valid), 32'd0);
    end
    chk("req033.result_valid", 32'(bus.result_valid), 32'd1);
    chk("req033.class_idx", 32'(bus.class_idx), 32'd2);
    chk("req033.max_val", bus.max_val, 32'd40);
    bus.rd_addr = 4'd1;
    #1;
    chk("req033.rd1", bus.rd_data, 32'd0);
    bus.rd_addr = 4'd7;
    #1;
    chk("req033.rd7", bus.rd_data, 32'd0);
    bus.rd_addr = 4'd8;
    #1;
    chk("req033.rd8", bus.rd_data, 32'd39);

    // Edge in DONE must be ignored
    pulse("done_edge", 32'd1000);
    cycle("done_chk", 1'b1);
    chk("done_edge.max_val", bus.max_val, 32'd40);

    // All negative
    do_start();
    for (int i = 0; i < N; i++) begin
      pulse($sformatf("req034.cap%0d", i),
            (i == 0) ? 32'h8000_0000 : (i == N - 1) ? 32'hFFFF_FFFF : (32'h8000_0000 | $urandom));
    end
    chk("req034.result_valid", 32'(bus.result_valid), 32'd1);
    chk("req034.class_idx", 32'(bus.class_idx), 32'd0);
    chk("req034.max_val", bus.max_val, 32'd0);

    // Held done_flag gives exactly one capture
    do_start();
    bus.pe_out    = 32'd9;
    bus.done_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle($sformatf("req035.held%0d", i));
      chk("req035.busy", 32'(bus.busy), 32'd1);
    end
    bus.done_flag = 1'b0;
    cycle("req035.release", 1'b1);
    bus.rd_addr = 4'd0;
    #1;
    chk("req035.rd0", bus.rd_data, 32'd9);
    for (int i = 0; i < N - 2; i++) pulse($sformatf("req035.cap%0d", i + 1), rand_val());
    chk("req035.valid_after9", 32'(bus.result_valid), 32'd0);
    pulse("req035.cap9", rand_val());
    chk("req035.valid_after10", 32'(bus.result_valid), 32'd1);

    // start and rising done_flag in the same cycle
    do_start();
    pulse("req036.pre", 32'd77);
    bus.start     = 1'b1;
    bus.done_flag = 1'b1;
    bus.pe_out    = 32'd55;
    cycle("req036.simul", 1'b1);
    bus.start = 1'b0;
    bus.rd_addr = 4'd0;
    #1;
    chk("req036.rd0", bus.rd_data, 32'd0);
    bus.done_flag = 1'b0;
    cycle("req036.lo");
    for (int i = 0; i < N - 1; i++) pulse($sformatf("req036.cap%0d", i), rand_val());
    chk("req036.valid_after9", 32'(bus.result_valid), 32'd0);
    pulse("req036.cap9", rand_val());
    chk("req036.valid_after10", 32'(bus.result_valid), 32'd1);

    // Reset mid-collection with done_flag held high
    do_start();
    for (int i = 0; i < 3; i++) pulse($sformatf("req037.cap%0d", i), 32'(100 + i));
    bus.pe_out    = 32'd11;
    bus.done_flag = 1'b1;
    cycle("req037.cap3");
    rst = 1'b1;
    cycle("req037.reset", 1'b1);
    rst = 1'b0;
    cycle("req037.post_reset", 1'b1);
    chk("req037.busy", 32'(bus.busy), 32'd0);
    chk("req037.result_valid", 32'(bus.result_valid), 32'd0);
    chk("req037.max_val", bus.max_val, 32'd0);
    chk("req037.class_idx", 32'(bus.class_idx), 32'd0);
    do_start();
    cycle("req037.still_high", 1'b1);
    bus.rd_addr = 4'd0;
    #1;
    chk("req037.no_capture", bus.rd_data, 32'd0);
    bus.done_flag = 1'b0;
    cycle("req037.fall");
    for (int i = 0; i < N; i++) pulse($sformatf("req037.fresh%0d", i), rand_val());
    chk("req037.result_valid_final", 32'(bus.result_valid), 32'd1);

    // Randomized runs with occasional restarts and resets
    for (int run = 0; run < 6; run++) begin
      do_start();
      guard = 0;
      while (m_mode != M_DONE && guard < 400) begin
        guard++;
        r = $urandom_range(0, 99);
        if (r < 3 && guard > 5) begin
          do_start();
        end else if (r < 4 && guard > 5) begin
          rst = 1'b1;
          cycle($sformatf("rand%0d.reset", run));
          rst = 1'b0;
          do_start();
        end else if (r < 70) begin
          pulse($sformatf("rand%0d.cap", run), rand_val());
        end else begin
          cycle($sformatf("rand%0d.idle", run));
        end
      end
      chk($sformatf("rand%0d.result_valid", run), 32'(bus.result_valid), 32'd1);
      cycle($sformatf("rand%0d.final", run), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
